// File: rtl/shift_arbiter.sv
// ---------------------------------------------------------------------------
// shift_arbiter
//   Shares one 32-bit barrel shifter between two requesters:
//   r0 = integer ALU path, r1 = multiply/divide sequencer.
//   Round-robin arbitration, operand capture on accept, a registered result,
//   and a per-requester valid/ready response handshake.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   rX_valid / rX_ready        request handshake for requester X (0/1)
//   rX_a / rX_b / rX_op        operand, shift amount, op (00 asr, 01 lsr, 1x lsl)
//   rspX_valid / rspX_ready    response handshake for requester X
//   rsp_c, rsp_carry           shared registered result and carry-out
//   busy                       high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module barrel_shifter #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [DATA_W-1:0]  a_i,
    input  logic [SHAMT_W-1:0] b_i,
    input  logic [1:0]         op_i,
    output logic [DATA_W-1:0]  c_o,
    output logic               carry_o
);

    logic [SHAMT_W-1:0] right_idx;
    logic [SHAMT_W-1:0] left_idx;

    // Carry is the last bit shifted out: a[b-1] for right shifts and
    // a[32-b] for left shifts. 32-b modulo 32 equals 0-b in 5 bits, and
    // b==0 is handled separately, so both indices stay in range.
    always_comb begin
        right_idx = b_i - SHAMT_W'(1);
        left_idx  = SHAMT_W'(0) - b_i;
        c_o       = a_i;
        carry_o   = 1'b0;
        if (b_i != '0) begin
            case (op_i)
                2'b00: begin
                    c_o     = $signed(a_i) >>> b_i;
                    carry_o = a_i[right_idx];
                end
                2'b01: begin
                    c_o     = a_i >> b_i;
                    carry_o = a_i[right_idx];
                end
                default: begin
                    c_o     = a_i << b_i;
                    carry_o = a_i[left_idx];
                end
            endcase
        end
    end

endmodule

module shift_arbiter #(
    parameter int DATA_W    = 32,
    parameter int SHAMT_W   = 5,
    parameter int FIRST_PRI = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               r0_valid,
    output logic               r0_ready,
    input  logic [DATA_W-1:0]  r0_a,
    input  logic [SHAMT_W-1:0] r0_b,
    input  logic [1:0]         r0_op,
    input  logic               r1_valid,
    output logic               r1_ready,
    input  logic [DATA_W-1:0]  r1_a,
    input  logic [SHAMT_W-1:0] r1_b,
    input  logic [1:0]         r1_op,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [DATA_W-1:0]  rsp_c,
    output logic               rsp_carry,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic PTR_RESET = (FIRST_PRI != 0);

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic               gnt_q, gnt_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [SHAMT_W-1:0] b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic [DATA_W-1:0]  c_q, c_d;
    logic               carry_q, carry_d;

    logic [DATA_W-1:0]  sh_c;
    logic               sh_carry;
    logic               grant;

    barrel_shifter #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .a_i     (a_q),
        .b_i     (b_q),
        .op_i    (op_q),
        .c_o     (sh_c),
        .carry_o (sh_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= PTR_RESET;
            gnt_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            c_q     <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            c_q     <= c_d;
            carry_q <= carry_d;
        end
    end

    // A lone valid requester wins regardless of the pointer; under
    // contention the pointer decides and then flips to the loser.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        c_d        = c_q;
        carry_d    = carry_q;
        r0_ready   = 1'b0;
        r1_ready   = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        grant      = (r0_valid && r1_valid) ? ptr_q : r1_valid;

        case (state_q)
            IDLE: begin
                if (r0_valid || r1_valid) begin
                    r0_ready = !grant;
                    r1_ready = grant;
                    gnt_d    = grant;
                    ptr_d    = !grant;
                    a_d      = grant ? r1_a  : r0_a;
                    b_d      = grant ? r1_b  : r0_b;
                    op_d     = grant ? r1_op : r0_op;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                c_d     = sh_c;
                carry_d = sh_carry;
                state_d = RESP;
            end
            RESP: begin
                rsp0_valid = !gnt_q;
                rsp1_valid = gnt_q;
                if (gnt_q ? rsp1_ready : rsp0_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rsp_c     = c_q;
    assign rsp_carry = carry_q;
    assign busy      = (state_q != IDLE);

endmodule
